// File: rtl/mp_types_pkg.sv
// mp_types: shared enums and operand helpers for the mixed-precision systolic engine.
package mp_types;
  typedef enum logic [1:0] {PREC_INT8 = 2'd0, PREC_INT16 = 2'd1} prec_e;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} sysa_state_e;
  // Unknown precision encodings fall back to INT8.
  function automatic logic signed [15:0] sext_lane(input logic [31:0] lane, input prec_e prec);
    return (prec == PREC_INT16) ? lane[15:0] : {{8{lane[7]}}, lane[7:0]};
  endfunction
endpackage

// File: rtl/mp_systolic_engine_pe.sv
// mp_sysa_pe: one processing element with registered A/B pass-through and a signed MAC.
// Saturating accumulation when MP_SYSA_SAT_EN is defined, two's-complement wrap otherwise.
module mp_sysa_pe #(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [15:0]      a_i,
  input  logic signed [15:0]      b_i,
  output logic signed [15:0]      a_o,
  output logic signed [15:0]      b_o,
  output logic [ACC_W-1:0]        acc_o
`ifdef MP_SYSA_SAT_EN
  ,output logic                   sat_o
`endif
);
  logic signed [31:0] prod;
  logic signed [ACC_W-1:0] prod_x, acc_q, acc_d;
  assign prod = a_i * b_i;
  assign prod_x = ACC_W'(prod);
`ifdef MP_SYSA_SAT_EN
  logic signed [ACC_W:0] sum;
  logic ovf;
  assign sum = {acc_q[ACC_W-1], acc_q} + {prod_x[ACC_W-1], prod_x};
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign sat_o = en & ovf;
  assign acc_d = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
`else
  assign acc_d = acc_q + prod_x;
`endif
  assign acc_o = acc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_o   <= '0;
      b_o   <= '0;
      acc_q <= '0;
    end else if (clr) begin
      a_o   <= '0;
      b_o   <= '0;
      acc_q <= '0;
    end else if (en) begin
      a_o   <= a_i;
      b_o   <= b_i;
      acc_q <= acc_d;
    end
endmodule

// File: rtl/mp_systolic_engine.sv
// mp_systolic_engine: output-stationary NxN systolic matmul with skewing, flush and row drain.
// Define MP_SYSA_SAT_EN for saturating accumulation and the sticky sat_flag output.
module mp_systolic_engine
  import mp_types::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int KW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  prec_e                        cfg_prec,
  input  logic [KW-1:0]                cfg_k,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*32-1:0]              in_a,
  input  logic [N*32-1:0]              in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*ACC_W-1:0]           out_data,
  output logic [((N>1)?$clog2(N):1)-1:0] out_row,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
`ifdef MP_SYSA_SAT_EN
  ,output logic                        sat_flag
`endif
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FL = (N > 1) ? 2*N-3 : 0;
  sysa_state_e state_q;
  prec_e prec_q;
  logic [KW-1:0] k_q, cnt_q;
  logic [RW-1:0] row_q;
  logic done_q, accept, fire, step;
  logic signed [15:0] a_inj [N];
  logic signed [15:0] b_inj [N];
  logic signed [15:0] a_h [N][N+1];
  logic signed [15:0] b_v [N+1][N];
  logic [ACC_W-1:0] acc [N][N];
  assign cfg_ready = state_q == IDLE;
  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign out_row   = row_q;
  assign out_last  = out_valid & (row_q == RW'(N-1));
  assign accept    = cfg_valid & cfg_ready;
  assign fire      = in_valid & in_ready;
  assign step      = fire | (state_q == FLUSH);
`ifdef MP_SYSA_SAT_EN
  logic [N*N-1:0] sat_v;
  logic sat_q;
  assign sat_flag = sat_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sat_q <= 1'b0;
    else sat_q <= accept ? 1'b0 : (sat_q | (|sat_v));
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      prec_q  <= PREC_INT8;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_valid) begin
          prec_q  <= cfg_prec;
          k_q     <= cfg_k;
          cnt_q   <= '0;
          row_q   <= '0;
          state_q <= (cfg_k == '0) ? DRAIN : LOAD;
        end
        LOAD: if (in_valid) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == k_q - 1'b1) begin
            cnt_q   <= '0;
            state_q <= (N == 1) ? DRAIN : FLUSH;
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == KW'(FL)) begin
            cnt_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: if (out_ready) begin
          row_q <= row_q + 1'b1;
          if (row_q == RW'(N-1)) begin
            row_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  // Row i / column i operands pass through an i-deep delay line so beat k meets PE(i,j) at step k+i+j.
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_inj[i] = (state_q == LOAD) ? sext_lane(in_a[32*i +: 32], prec_q) : '0;
    assign b_inj[i] = (state_q == LOAD) ? sext_lane(in_b[32*i +: 32], prec_q) : '0;
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_inj[0];
      assign b_v[0][0] = b_inj[0];
    end else begin : g_delay
      logic signed [15:0] sa_q [i];
      logic signed [15:0] sb_q [i];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          sa_q <= '{default: '0};
          sb_q <= '{default: '0};
        end else if (accept) begin
          sa_q <= '{default: '0};
          sb_q <= '{default: '0};
        end else if (step) begin
          sa_q[0] <= a_inj[i];
          sb_q[0] <= b_inj[i];
          for (int d = 1; d < i; d++) begin
            sa_q[d] <= sa_q[d-1];
            sb_q[d] <= sb_q[d-1];
          end
        end
      assign a_h[i][0] = sa_q[i-1];
      assign b_v[0][i] = sb_q[i-1];
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      mp_sysa_pe #(.ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (step),
        .clr   (accept),
        .a_i   (a_h[i][j]),
        .b_i   (b_v[i][j]),
        .a_o   (a_h[i][j+1]),
        .b_o   (b_v[i+1][j]),
        .acc_o (acc[i][j])
`ifdef MP_SYSA_SAT_EN
        ,.sat_o(sat_v[i*N+j])
`endif
      );
    end
  end
  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) out_data[j*ACC_W +: ACC_W] = out_valid ? acc[row_q][j] : '0;
  end
endmodule

// File: tb/tb_mp_systolic_engine.sv
// tb_mp_systolic_engine: table-driven directed bench for mp_systolic_engine (N=4, ACC_W=32).
module tb_mp_systolic_engine;
  import mp_types::*;
  localparam int N = 4, AW = 32, KW = 16;
  typedef struct {
    prec_e       prec;
    int          k;
    logic [31:0] a [4][4];
    logic [31:0] b [4][4];
    logic [31:0] c [4][4];
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, in_valid = 1'b0, in_ready;
  prec_e cfg_prec = PREC_INT8;
  logic [KW-1:0] cfg_k = '0;
  logic [N*32-1:0] in_a = '0, in_b = '0;
  logic out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [N*AW-1:0] out_data;
  logic [1:0] out_row;
`ifdef MP_SYSA_SAT_EN
  logic sat_flag;
`endif
  vec_t vt [9];
  logic [31:0] res [4][4];
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  mp_systolic_engine #(.N(N), .ACC_W(AW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prec(cfg_prec),
    .cfg_k(cfg_k), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef MP_SYSA_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic signed [31:0] sx(input logic [31:0] l, input prec_e p);
    return (p == PREC_INT16) ? {{16{l[15]}}, l[15:0]} : {{24{l[7]}}, l[7:0]};
  endfunction
  task automatic model(input int v);
    logic signed [31:0] s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int t = 0; t < vt[v].k; t++) s += sx(vt[v].a[t][i], vt[v].prec) * sx(vt[v].b[t][j], vt[v].prec);
        vt[v].c[i][j] = s;
      end
  endtask
  task automatic reset_outs(input string n);
    chk({n, "_cfg_ready"}, cfg_ready, 1);
    chk({n, "_in_ready"}, in_ready, 0);
    chk({n, "_out_valid"}, out_valid, 0);
    chk({n, "_out_data"}, out_data, 0);
    chk({n, "_out_row"}, out_row, 0);
    chk({n, "_out_last"}, out_last, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
  endtask
  task automatic run_job(input int v, input bit tog, input bit stall, input bit poke, input bit abort);
    int w;
    logic [N*AW-1:0] hold;
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_prec = vt[v].prec;
    cfg_k = KW'(vt[v].k);
    tick;
    cfg_valid = 1'b0;
    for (int t = 0; t < vt[v].k; t++) begin
      if (tog) begin
        in_valid = 1'b0;
        in_a = '1;
        in_b = '1;
        tick;
      end
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[32*i +: 32] = vt[v].a[t][i];
        in_b[32*i +: 32] = vt[v].b[t][i];
      end
      chk("in_ready_load", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
    if (abort) begin
      tick;
      tick;
      chk("busy_in_flush", busy, 1);
      rst = 1'b1;
      #2;
      reset_outs("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick;
      return;
    end
    w = 0;
    while (!out_valid && w < 40) begin
      tick;
      w++;
    end
    chk("flush_len", w, (vt[v].k == 0) ? 0 : 2*N-2);
    if (poke) begin
      cfg_valid = 1'b1;
      cfg_k = 3;
    end
    out_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      chk("out_valid", out_valid, 1);
      chk("out_row", out_row, r);
      chk("out_last", out_last, r == N-1);
      for (int j = 0; j < N; j++) res[r][j] = out_data[j*AW +: AW];
      if (poke) chk("cfg_ready_drain", cfg_ready, 0);
      if (stall && r == 1) begin
        out_ready = 1'b0;
        hold = out_data;
        repeat (3) begin
          tick;
          chk("stall_hold", out_data, hold);
          chk("stall_row", out_row, 1);
        end
        out_ready = 1'b1;
      end
      if (poke && r == N-1) cfg_valid = 1'b0;
      tick;
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    tick;
    chk("done_clear", done, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) chk($sformatf("c_v%0d_%0d%0d", v, i, j), res[i][j], vt[v].c[i][j]);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] bl [4], cl [4];
    bl = '{32'h05, 32'hFB, 32'h7F, 32'h80};
    cl = '{32'h5, 32'hFFFFFFFB, 32'h7F, 32'hFFFFFF80};
    foreach (vt[v]) begin
      vt[v].prec = PREC_INT8;
      vt[v].k = 0;
      for (int t = 0; t < 4; t++)
        for (int i = 0; i < 4; i++) begin
          vt[v].a[t][i] = '0;
          vt[v].b[t][i] = '0;
          vt[v].c[t][i] = '0;
        end
    end
    vt[0].k = 1;
    for (int i = 0; i < 4; i++) begin
      vt[0].a[0][i] = i + 1;
      vt[0].b[0][i] = 1;
      for (int j = 0; j < 4; j++) vt[0].c[i][j] = i + 1;
    end
    vt[1].k = 4;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++) begin
        vt[1].a[t][i] = (t == i) ? 32'h1 : 32'h0;
        vt[1].b[t][i] = bl[i];
        vt[1].c[t][i] = cl[i];
      end
    vt[2].prec = PREC_INT16;
    vt[2].k = 3;
    vt[3].k = 3;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 4; i++) begin
        vt[2].a[t][i] = 32'h0000FFFF;
        vt[2].b[t][i] = 32'h00000002;
        vt[3].a[t][i] = 32'h0000FFFF;
        vt[3].b[t][i] = 32'h00000002;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        vt[2].c[i][j] = 32'hFFFFFFFA;
        vt[3].c[i][j] = 32'hFFFFFFFA;
      end
    vt[4].prec = PREC_INT16;
    vt[4].k = 2;
    vt[5].k = 4;
    vt[6].k = 2;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++) begin
        vt[4].a[t][i] = 32'hA5A50000 ^ (32'(t*4 + i) * 32'h1F3D);
        vt[4].b[t][i] = 32'h5A5A0000 ^ (32'(t*7 + i + 1) * 32'h0E71);
        vt[5].a[t][i] = vt[4].a[t][i];
        vt[5].b[t][i] = vt[4].b[t][i];
        vt[6].a[t][i] = 32'h000000C0 + 32'(t*17 + i*9);
        vt[6].b[t][i] = 32'h00000003 + 32'(t*5 + i*11);
      end
    model(4);
    model(5);
    model(6);
    vt[8].prec = PREC_INT16;
    vt[8].k = 3;
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 4; i++) begin
        vt[8].a[t][i] = 32'h7FFF;
        vt[8].b[t][i] = 32'h7FFF;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) vt[8].c[i][j] = 32'h7FFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    reset_outs("reset");
    rst = 1'b0;
    tick;
    for (int v = 0; v < 6; v++) run_job(v, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_job(7, 1'b0, 1'b0, 1'b1, 1'b0);
    run_job(4, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(6, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MP_SYSA_SAT_EN
    run_job(8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_flag", sat_flag, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mp_systolic_engine.md
Name: mp_systolic_engine

Overview:
- Output-stationary NxN systolic matrix-multiply engine: C[N][N] = sum over k of A[:,k]·B[k,:].
- Generational successor of the fixed-precision PE grid:
  - runtime precision select
  - configurable reduction depth K
  - internal input skewing
  - valid/ready streaming in and out
  - FSM-sequenced flush and row-wise result drain
- Sits between the operand fetch buffers and the result writeback path of the mixed-precision core.

Parameters:
- N, 4, array dimension (rows = cols = N), N >= 1.
- ACC_W, 32, accumulator and result lane width, >= 32.
- KW, 16, width of the K-length configuration field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  high only in IDLE.
- cfg_prec  in  prec_e  operand precision for the job.
- cfg_k  in  KW  number of reduction beats K.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- in_a  in  N*32  column k of A; lane i (bits [32i+31:32i]) belongs to row i.
- in_b  in  N*32  row k of B; lane j belongs to column j.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- out_data  out  N*ACC_W  row r of C; lane j = C[r][j].
- out_row  out  $clog2(N) (min 1)  index r of the current row.
- out_last  out  1  high with row N-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (async, rst=1):
  - FSM = IDLE; all accumulators, skew and pipeline registers cleared.
  - Outputs: cfg_ready=1, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0, done=0.
  - Reset mid-job aborts the job; no partial results are emitted.
- States and transitions:
  - IDLE -> LOAD on cfg_valid & cfg_ready.
    - Latches prec and K; clears all accumulators and the skew pipeline that cycle.
    - If K==0, goes directly to DRAIN with zero results.
  - LOAD: in_ready=1.
    - Each fire (in_valid & in_ready) advances the array one step.
    - No fire = global stall; no PE or skew register changes.
    - After K fires -> FLUSH, or -> DRAIN if N==1.
  - FLUSH: array advances every cycle with zero operands injected; exactly 2N-2 cycles, then DRAIN.
  - DRAIN:
    - out_valid=1; row r is presented with out_row=r; out_last=(r==N-1).
    - On out_valid & out_ready, r increments.
    - out_data is held stable while out_ready=0.
    - After row N-1 is accepted -> IDLE; done=1 for that next cycle.
- Skew and dataflow:
  - Row i operand delayed i steps; column j operand delayed j steps.
  - A operands move right one PE per step; B operands move down one PE per step.
  - PE(i,j) consumes beat k at step k+i+j. Total steps = K+2N-2; every product lands before DRAIN.
- Arithmetic:
  - PREC_INT8: lane bits [7:0] are signed; product is 16b, sign-extended to ACC_W.
  - PREC_INT16: lane bits [15:0] are signed; product is 32b, sign-extended to ACC_W.
  - Any other prec_e encoding behaves as PREC_INT8.
  - Accumulation is two's-complement wrap at ACC_W bits.
- Simultaneous events:
  - cfg_valid outside IDLE is ignored (cfg_ready=0).
  - in_valid outside LOAD is ignored.
  - The final LOAD fire and the FLUSH entry occur in the same cycle.

Optional Feature:
- MP_SYSA_SAT_EN defined: each accumulate saturates to signed ACC_W max/min instead of wrapping. A sticky sat_flag output (1 bit, reset 0, cleared on job accept) is set if any PE saturated during the job.
- Undefined: wrap arithmetic; the sat_flag port is absent.

Decomposition:
- Add to mp_types:
  - prec_e members PREC_INT8 and PREC_INT16.
  - sysa_state_e {IDLE, LOAD, FLUSH, DRAIN}.
  - Function sext_lane(lane, prec) returning a signed 16b operand.
- Sub-module mp_sysa_pe:
  - Registered A-right and B-down pass-through.
  - Global step enable and clear.
  - Precision-aware MAC with optional saturation.
- Instantiated NxN by generate.

Test Plan:
- N=4, INT8, K=1, a=[1,2,3,4], b=[1,1,1,1] -> rows C[i][*]=i+1; four rows drained with out_row 0..3, out_last on row 3, done one cycle after.
- INT8 identity: K=4, A=I, B lanes=[0x05,0xFB,0x7F,0x80] -> C rows equal B rows (5,-5,127,-128 sign-extended).
- INT16 mixed: lane 0x0000FFFF × 0x00000002 with K=3 -> C=-6; same data under INT8 -> -6 (low bytes 0xFF and 0x02).
- Backpressure: in_valid toggled every other cycle during LOAD, and out_ready low for 3 cycles mid-DRAIN -> results identical to the unstalled run; out_data stable while stalled.
- K=0 -> DRAIN immediately, all-zero rows; cfg_valid asserted during DRAIN is not accepted.
- rst asserted mid-FLUSH -> next job K=2 yields correct results with no residue. With MP_SYSA_SAT_EN: INT16, 0x7FFF×0x7FFF, K=3, ACC_W=32 -> C=0x7FFFFFFF and sat_flag=1.
